// File: rtl/hmc_rf_responder.sv
// hmc_rf_responder: responder end of the HMC register-file access port.
// Accepts one read or write at a time and completes it ACCESS_LAT cycles
// later with a single-cycle rf_access_complete pulse.
//   addr 0            : ID (read-only, ID_VALUE)
//   addr 1            : ACCESS_CNT (read-only, 32-bit, zero-extended)
//   addr 2..NUM_REGS-1: 64-bit scratch registers
//   addr >= NUM_REGS  : invalid (completes with rf_invalid_address)
// Optional build macro RF_CLEAR_ON_READ_EN: a valid read of ACCESS_CNT
// returns the current count and then clears it.
// ACCESS_CNT_RESET sets the counter's reset value (0 for normal operation);
// it lets bring-up benches start the counter close to its wrap point.
module hmc_rf_responder #(
  parameter int unsigned NUM_REGS         = 8,
  parameter int unsigned ACCESS_LAT       = 2,
  parameter logic [63:0] ID_VALUE         = 64'h0000_0000_484D_4301,
  parameter logic [31:0] ACCESS_CNT_RESET = 32'h0000_0000
) (
  input  logic        clk_hmc,
  input  logic        res_hmc,
  input  logic [3:0]  rf_address,
  input  logic        rf_write_en,
  input  logic        rf_read_en,
  input  logic [63:0] rf_write_data,
  output logic [63:0] rf_read_data,
  output logic        rf_access_complete,
  output logic        rf_invalid_address
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);
  localparam logic [3:0] LAT_M1     = 4'(ACCESS_LAT - 1);

  state_t      state;
  logic [3:0]  lat_cnt;
  logic [3:0]  op_addr;
  logic        op_write;
  logic        op_invalid;
  logic [63:0] op_data;
  logic [31:0] access_cnt;
  logic [63:0] scratch [16];
  logic [63:0] read_value;
  logic        addr_out_of_range;
  logic        clear_on_read;

  assign addr_out_of_range = ({1'b0, rf_address} >= NUM_REGS_W);

`ifdef RF_CLEAR_ON_READ_EN
  assign clear_on_read = !op_write && (op_addr == 4'd1);
`else
  assign clear_on_read = 1'b0;
`endif

  // Read mux over the register map for the latched address.
  always_comb begin
    // NOTE: default assignment first so no path leaves read_value unassigned (no latch).
    read_value = scratch[op_addr];
    if (op_addr == 4'd0) begin
      read_value = ID_VALUE;
    end else if (op_addr == 4'd1) begin
      read_value = {32'd0, access_cnt};
    end
  end

  // Access FSM: latch request, count latency, then complete with registered outputs.
  always_ff @(posedge clk_hmc) begin
    if (res_hmc) begin
      state              <= ST_IDLE;
      lat_cnt            <= 4'd0;
      op_addr            <= 4'd0;
      op_write           <= 1'b0;
      op_invalid         <= 1'b0;
      op_data            <= 64'd0;
      access_cnt         <= ACCESS_CNT_RESET;
      rf_read_data       <= 64'd0;
      rf_access_complete <= 1'b0;
      rf_invalid_address <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here updates from pre-edge values.
      rf_access_complete <= 1'b0;
      rf_invalid_address <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rf_write_en || rf_read_en) begin
            op_addr    <= rf_address;
            op_write   <= rf_write_en;
            op_data    <= rf_write_data;
            op_invalid <= (rf_write_en && rf_read_en) || addr_out_of_range;
            lat_cnt    <= LAT_M1;
            state      <= (ACCESS_LAT == 1) ? ST_DONE : ST_BUSY;
          end
        end
        ST_BUSY: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          rf_access_complete <= 1'b1;
          rf_invalid_address <= op_invalid;
          rf_read_data       <= (op_invalid || op_write) ? 64'd0 : read_value;
          if (!op_invalid) begin
            access_cnt <= clear_on_read ? 32'd0 : access_cnt + 32'd1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Scratch registers: write committed on the completion edge of a valid write.
  always_ff @(posedge clk_hmc) begin
    if (res_hmc) begin
      // NOTE: the scratch array is cleared by reset because software expects 0 after reset.
      for (int i = 0; i < 16; i++) begin
        scratch[i] <= 64'd0;
      end
    end else if (state == ST_DONE && op_write && !op_invalid && op_addr >= 4'd2) begin
      scratch[op_addr] <= op_data;
    end
  end

endmodule
